// File: rtl/tmr_pkg.sv
// Shared helpers for the tmr_* family of triple-redundant storage elements.
// Both functions work on a single bit so callers can apply them to any width.
package tmr_pkg;

    // Two-of-three majority of one bit position.
    function automatic logic tmr_maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // High when the three copies of one bit position do not all agree.
    function automatic logic tmr_mismatch(input logic a, input logic b, input logic c);
        return (a ^ b) | (a ^ c);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Combinational voter: bitwise 2-of-3 majority of three copies plus a flag
// that is raised whenever any bit of any copy disagrees with the others.
module tmr_vote
    import tmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q,
    output logic             mismatch
);

    logic [WIDTH-1:0] diff;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign q[i]    = tmr_maj(q1[i], q2[i], q3[i]);
        assign diff[i] = tmr_mismatch(q1[i], q2[i], q3[i]);
    end

    assign mismatch = |diff;

endmodule

// File: rtl/tmr_reg_scrub.sv
// Triple-modular-redundant register with load, periodic scrub (voted value
// written back into all copies), mismatch detection and a saturating count of
// correction events (copies written while they disagreed).
module tmr_reg_scrub
    import tmr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int               SCRUB_PERIOD = 1,
    parameter int               CNT_W        = 8
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Kept as three distinct registers through synthesis; merging them would
    // defeat the redundancy.
    (* syn_preserve = 1 *) logic [WIDTH-1:0] q1;
    (* syn_preserve = 1 *) logic [WIDTH-1:0] q2;
    (* syn_preserve = 1 *) logic [WIDTH-1:0] q3;

    logic             scrub_now;
    logic             wr;
    logic [WIDTH-1:0] wr_val;

    tmr_vote #(.WIDTH(WIDTH)) u_vote (
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .q        (q),
        .mismatch (mismatch)
    );

    if (SCRUB_PERIOD > 0) begin : g_scrub
        localparam int            SCW  = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
        localparam logic [SCW-1:0] LAST = SCW'(SCRUB_PERIOD - 1);

        logic [SCW-1:0] scrub_cnt;

        // Idle-cycle counter: restarts on a write and wraps after each scrub.
        always_ff @(posedge c or negedge r) begin
            if (!r) begin
                scrub_cnt <= '0;
            end else if (en || (scrub_cnt == LAST)) begin
                scrub_cnt <= '0;
            end else begin
                scrub_cnt <= scrub_cnt + 1'b1;
            end
        end

        assign scrub_now = !en && (scrub_cnt == LAST);
    end else begin : g_no_scrub
        assign scrub_now = 1'b0;
    end

    // A load wins over a scrub and writes d rather than the voted value.
    assign wr     = en | scrub_now;
    assign wr_val = en ? d : q;

    // Copy registers: loaded together from d or refreshed from the vote.
    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            q1 <= RESET_VAL;
            q2 <= RESET_VAL;
            q3 <= RESET_VAL;
        end else if (wr) begin
            // NOTE: non-blocking so every copy takes the vote formed from the
            // pre-edge values, not from a copy already updated this edge.
            q1 <= wr_val;
            q2 <= wr_val;
            q3 <= wr_val;
        end
    end

    // Correction-event counter and sticky flag; clear beats a same-edge event.
    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (cnt_clr) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (wr && mismatch) begin
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmr_reg_scrub.sv
// Self-checking bench for tmr_reg_scrub. Two instances: one scrubbing every
// fourth idle cycle with a 2-bit counter, one with scrubbing disabled.
// Expected values come from a behavioural model of the register's rules.
module tb_tmr_reg_scrub;

    localparam int             W    = 8;
    localparam logic [W-1:0]   RV_A = 8'h3C;
    localparam int             SP_A = 4;
    localparam int             CW_A = 2;
    localparam int             CW_B = 8;

    typedef struct {
        logic [W-1:0] c1;
        logic [W-1:0] c2;
        logic [W-1:0] c3;
        int           idle;
        int           cnt;
        bit           sticky;
    } model_t;

    logic c = 1'b0;
    logic r = 1'b0;

    logic            en_a = 1'b0, clr_a = 1'b0;
    logic [W-1:0]    d_a = '0;
    logic [W-1:0]    q_a;
    logic            mm_a, st_a;
    logic [CW_A-1:0] cnt_a;

    logic            en_b = 1'b0, clr_b = 1'b0;
    logic [W-1:0]    d_b = '0;
    logic [W-1:0]    q_b;
    logic            mm_b, st_b;
    logic [CW_B-1:0] cnt_b;

    int     n_tests = 0;
    int     n_fail  = 0;
    model_t ma, mb;

    always #5 c = ~c;

    tmr_reg_scrub #(.WIDTH(W), .RESET_VAL(RV_A), .SCRUB_PERIOD(SP_A), .CNT_W(CW_A)) dut (
        .c(c), .r(r), .en(en_a), .d(d_a), .cnt_clr(clr_a),
        .q(q_a), .mismatch(mm_a), .err_sticky(st_a), .err_cnt(cnt_a)
    );

    tmr_reg_scrub #(.WIDTH(W), .RESET_VAL(8'h00), .SCRUB_PERIOD(0), .CNT_W(CW_B)) dut_ns (
        .c(c), .r(r), .en(en_b), .d(d_b), .cnt_clr(clr_b),
        .q(q_b), .mismatch(mm_b), .err_sticky(st_b), .err_cnt(cnt_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] vote(input model_t m);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            v[i] = (int'(m.c1[i]) + int'(m.c2[i]) + int'(m.c3[i])) >= 2;
        end
        return v;
    endfunction

    function automatic bit disagree(input model_t m);
        return (m.c1 != m.c2) || (m.c1 != m.c3);
    endfunction

    function automatic model_t model_reset(input logic [W-1:0] rv);
        model_t m;
        m.c1 = rv; m.c2 = rv; m.c3 = rv;
        m.idle = 0; m.cnt = 0; m.sticky = 0;
        return m;
    endfunction

    function automatic model_t model_next(input model_t m, input logic en, input logic [W-1:0] d,
                                          input logic clr, input int period, input int cnt_max);
        model_t       n;
        bit           written;
        logic [W-1:0] val;
        n = m;
        written = 0;
        val = '0;
        if (en) begin
            written = 1; val = d; n.idle = 0;
        end else if (period > 0) begin
            if (m.idle + 1 == period) begin
                written = 1; val = vote(m); n.idle = 0;
            end else begin
                n.idle = m.idle + 1;
            end
        end
        if (written) begin
            n.c1 = val; n.c2 = val; n.c3 = val;
        end
        if (clr) begin
            n.cnt = 0; n.sticky = 0;
        end else if (written && disagree(m)) begin
            n.cnt = (m.cnt < cnt_max) ? m.cnt + 1 : cnt_max;
            n.sticky = 1;
        end
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic ea, input logic [W-1:0] da, input logic ca,
                         input logic eb, input logic [W-1:0] db, input logic cb);
        en_a = ea; d_a = da; clr_a = ca;
        en_b = eb; d_b = db; clr_b = cb;
        ma = model_next(ma, ea, da, ca, SP_A, (1 << CW_A) - 1);
        mb = model_next(mb, eb, db, cb, 0, (1 << CW_B) - 1);
        @(posedge c);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic upset_a(input int copy, input int b);
        case (copy)
            0:       begin ma.c1[b] = ~ma.c1[b]; dut.q1 = ma.c1; end
            1:       begin ma.c2[b] = ~ma.c2[b]; dut.q2 = ma.c2; end
            default: begin ma.c3[b] = ~ma.c3[b]; dut.q3 = ma.c3; end
        endcase
        #1;
    endtask

    task automatic upset_b(input int copy, input int b);
        case (copy)
            0:       begin mb.c1[b] = ~mb.c1[b]; dut_ns.q1 = mb.c1; end
            1:       begin mb.c2[b] = ~mb.c2[b]; dut_ns.q2 = mb.c2; end
            default: begin mb.c3[b] = ~mb.c3[b]; dut_ns.q3 = mb.c3; end
        endcase
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        r = 1'b0;
        ma = model_reset(RV_A);
        mb = model_reset(8'h00);
        repeat (3) @(posedge c);
        #1;
        n_tests++;
        if ({q_a, mm_a, st_a, cnt_a} !== {RV_A, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_a: got q=%h mm=%b st=%b cnt=%0d, want q=%h mm=0 st=0 cnt=0",
                     q_a, mm_a, st_a, cnt_a, RV_A);
        end
        n_tests++;
        if ({q_b, mm_b, st_b, cnt_b} !== {8'h00, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_b: got q=%h mm=%b st=%b cnt=%0d, want q=00 mm=0 st=0 cnt=0",
                     q_b, mm_b, st_b, cnt_b);
        end
        @(negedge c);
        r = 1'b1;
        idle(1);
        n_tests++;
        if (q_a !== RV_A) begin
            n_fail++;
            $display("FAIL reset_release: got q=%h, want %h", q_a, RV_A);
        end
    endtask

    task automatic test_write();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if ({q_a, mm_a, st_a, cnt_a} !== {8'hA5, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL write: got q=%h mm=%b st=%b cnt=%0d, want q=a5 mm=0 st=0 cnt=0",
                     q_a, mm_a, st_a, cnt_a);
        end
    endtask

    task automatic test_upset_scrub();
        upset_a(1, 3);
        n_tests++;
        if ({q_a, mm_a} !== {8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL upset_masked: got q=%h mm=%b, want q=a5 mm=1", q_a, mm_a);
        end
        idle(SP_A);
        n_tests++;
        if ({dut.q1, dut.q2, dut.q3, mm_a, st_a, cnt_a} !== {8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL scrub: got copies=%h/%h/%h mm=%b st=%b cnt=%0d, want a5/a5/a5 mm=0 st=1 cnt=1",
                     dut.q1, dut.q2, dut.q3, mm_a, st_a, cnt_a);
        end
    endtask

    task automatic test_multi_upset();
        upset_a(0, 0);
        upset_a(2, 7);
        n_tests++;
        if ({q_a, mm_a} !== {8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL multi_masked: got q=%h mm=%b, want q=a5 mm=1", q_a, mm_a);
        end
        idle(SP_A);
        n_tests++;
        if ({dut.q1, dut.q2, dut.q3, mm_a, cnt_a} !== {8'hA5, 8'hA5, 8'hA5, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL multi_scrub: got copies=%h/%h/%h mm=%b cnt=%0d, want a5/a5/a5 mm=0 cnt=2",
                     dut.q1, dut.q2, dut.q3, mm_a, cnt_a);
        end
    endtask

    task automatic test_saturation_clear();
        for (int k = 0; k < 5; k++) begin
            upset_a(int'($urandom_range(0, 2)), int'($urandom_range(0, W - 1)));
            idle(SP_A);
        end
        n_tests++;
        if ({cnt_a, st_a, mm_a} !== {2'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d st=%b mm=%b, want cnt=3 st=1 mm=0", cnt_a, st_a, mm_a);
        end
        upset_a(2, 5);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if ({q_a, mm_a, st_a, cnt_a} !== {8'h5A, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL clr_priority: got q=%h mm=%b st=%b cnt=%0d, want q=5a mm=0 st=0 cnt=0",
                     q_a, mm_a, st_a, cnt_a);
        end
    endtask

    task automatic test_no_scrub();
        upset_b(2, 1);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            n_tests++;
            if ({q_b, mm_b, cnt_b} !== {8'h00, 1'b1, 8'd0}) begin
                n_fail++;
                $display("FAIL no_scrub_hold[%0d]: got q=%h mm=%b cnt=%0d, want q=00 mm=1 cnt=0",
                         k, q_b, mm_b, cnt_b);
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 8'h00, 1'b0);
        n_tests++;
        if ({dut_ns.q1, dut_ns.q2, dut_ns.q3, mm_b, st_b, cnt_b} !== {24'h0, 1'b0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL no_scrub_write: got copies=%h/%h/%h mm=%b st=%b cnt=%0d, want 00/00/00 mm=0 st=1 cnt=1",
                     dut_ns.q1, dut_ns.q2, dut_ns.q3, mm_b, st_b, cnt_b);
        end
    endtask

    task automatic test_random();
        logic         ea, ca, eb, cb;
        logic [W-1:0] da, db;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) upset_a(int'($urandom_range(0, 2)), int'($urandom_range(0, W - 1)));
            if ($urandom_range(0, 4) == 0) upset_b(int'($urandom_range(0, 2)), int'($urandom_range(0, W - 1)));
            ea = ($urandom_range(0, 5) == 0);
            eb = ($urandom_range(0, 7) == 0);
            ca = ($urandom_range(0, 19) == 0);
            cb = ($urandom_range(0, 19) == 0);
            da = W'($urandom);
            db = W'($urandom);
            cycle(ea, da, ca, eb, db, cb);
            n_tests++;
            if ({q_a, mm_a, st_a, cnt_a, dut.q1, dut.q2, dut.q3} !==
                {vote(ma), disagree(ma), ma.sticky, CW_A'(ma.cnt), ma.c1, ma.c2, ma.c3}) begin
                n_fail++;
                $display("FAIL random_a[%0d]: got q=%h mm=%b st=%b cnt=%0d, want q=%h mm=%b st=%b cnt=%0d",
                         k, q_a, mm_a, st_a, cnt_a, vote(ma), disagree(ma), ma.sticky, ma.cnt);
            end
            n_tests++;
            if ({q_b, mm_b, st_b, cnt_b} !== {vote(mb), disagree(mb), mb.sticky, CW_B'(mb.cnt)}) begin
                n_fail++;
                $display("FAIL random_b[%0d]: got q=%h mm=%b st=%b cnt=%0d, want q=%h mm=%b st=%b cnt=%0d",
                         k, q_b, mm_b, st_b, cnt_b, vote(mb), disagree(mb), mb.sticky, mb.cnt);
            end
        end
    endtask

    task automatic test_mid_reset();
        upset_a(0, 2);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1, 8'h77, 1'b0);
        upset_a(1, 4);
        upset_b(0, 6);
        #1;
        r = 1'b0;
        #1;
        ma = model_reset(RV_A);
        mb = model_reset(8'h00);
        n_tests++;
        if ({q_a, mm_a, st_a, cnt_a, dut.q1, dut.q2, dut.q3} !== {RV_A, 1'b0, 1'b0, 2'd0, RV_A, RV_A, RV_A}) begin
            n_fail++;
            $display("FAIL mid_reset_a: got q=%h mm=%b st=%b cnt=%0d, want q=%h mm=0 st=0 cnt=0",
                     q_a, mm_a, st_a, cnt_a, RV_A);
        end
        n_tests++;
        if ({q_b, mm_b, st_b, cnt_b} !== {8'h00, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_b: got q=%h mm=%b st=%b cnt=%0d, want q=00 mm=0 st=0 cnt=0",
                     q_b, mm_b, st_b, cnt_b);
        end
        r = 1'b1;
        cycle(1'b1, 8'h96, 1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if ({q_a, mm_a, cnt_a} !== {8'h96, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL after_reset_write: got q=%h mm=%b cnt=%0d, want q=96 mm=0 cnt=0",
                     q_a, mm_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_upset_scrub();
        test_multi_upset();
        test_saturation_clear();
        test_no_scrub();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
